// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, arbiter states and shared constants
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  localparam logic [31:0] ALU_ERR = 32'h0000_DEAD;

  function automatic logic is_legal_ctrl(input logic [3:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: is_legal_ctrl = 1'b1;
      default:                                   is_legal_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two requester ports and one response port of the arbitrated ALU
interface alu_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_op1;
  logic [31:0] req0_op2;
  logic [3:0]  req0_ctrl;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_op1;
  logic [31:0] req1_op2;
  logic [3:0]  req1_ctrl;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU; unknown codes yield ALU_ERR
module alu
  import alu_pkg::*;
(
  input  logic [31:0] ALUop1,
  input  logic [31:0] ALUop2,
  input  logic [3:0]  ALUctrl,
  output logic [31:0] ALUout,
  output logic        Zero
);

  always_comb begin
    ALUout = ALU_ERR;
    case (ALUctrl)
      ALU_ADD:  ALUout = ALUop1 + ALUop2;
      ALU_SUB:  ALUout = ALUop1 - ALUop2;
      ALU_SLL:  ALUout = ALUop1 << ALUop2[4:0];
      ALU_SLT:  ALUout = {31'b0, $signed(ALUop1) < $signed(ALUop2)};
      ALU_SLTU: ALUout = {31'b0, ALUop1 < ALUop2};
      ALU_XOR:  ALUout = ALUop1 ^ ALUop2;
      ALU_SRL:  ALUout = ALUop1 >> ALUop2[4:0];
      ALU_SRA:  ALUout = $unsigned($signed(ALUop1) >>> ALUop2[4:0]);
      ALU_OR:   ALUout = ALUop1 | ALUop2;
      ALU_AND:  ALUout = ALUop1 & ALUop2;
      default:  ALUout = ALU_ERR;
    endcase
    Zero = (ALUout == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic        rr_q, rr_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_illegal_q, rsp_illegal_d;

  logic        accept_open;
  logic        gnt;
  logic        xfer;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  // The output register can be refilled in the same cycle it drains.
  always_comb begin
    accept_open = (state_q == ST_IDLE) || bus.rsp_ready;
    gnt         = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
    xfer        = !rst && accept_open && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = xfer && !gnt;
  assign bus.req1_ready = xfer && gnt;

  always_comb begin
    alu_op1  = gnt ? bus.req1_op1  : bus.req0_op1;
    alu_op2  = gnt ? bus.req1_op2  : bus.req0_op2;
    alu_ctrl = gnt ? bus.req1_ctrl : bus.req0_ctrl;
  end

  alu u_alu (
    .ALUop1  (alu_op1),
    .ALUop2  (alu_op2),
    .ALUctrl (alu_ctrl),
    .ALUout  (alu_out),
    .Zero    (alu_zero)
  );

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    if (xfer) begin
      state_d       = ST_RESP;
      rr_d          = ~gnt;
      rsp_id_d      = gnt;
      rsp_result_d  = alu_out;
      rsp_zero_d    = alu_zero;
      rsp_illegal_d = !is_legal_ctrl(alu_ctrl);
    end else if ((state_q == ST_RESP) && bus.rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_q          <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_op1 = a; bus.req0_op2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_op1 = a; bus.req1_op2 = b;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'h0, 32'd0, 32'd0);
  endtask

  // Reference ALU written straight from the operation table.
  function automatic logic [33:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (c)
      4'b0000: r = a + b;
      4'b1001: r = a - b;
      4'b0001: r = a << b[4:0];
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: begin r = 32'h0000_DEAD; ill = 1'b1; end
    endcase
    return {ill, (r == 32'd0), r};
  endfunction

  logic        m_held;
  logic        m_id;
  logic [33:0] m_rsp;
  int          m_last;
  logic        pend  [2];
  logic        rv    [2];
  logic [3:0]  rc    [2];
  logic [31:0] ra    [2];
  logic [31:0] rb    [2];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    idle_inputs();

    vecs[0]  = '{1'b0, 4'b0000, 32'd5,          32'd7,         32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1001, 32'd3,          32'd3,         32'd0,          1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 32'hF0,         32'h0F,        32'hFF,         1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1101, 32'h8000_0000,  32'd4,         32'hF800_0000,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 32'd1,          32'd31,        32'h8000_0000,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd0,         32'd1,          1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b0011, 32'hFFFF_FFFF,  32'd0,         32'd0,          1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'b0101, 32'h8000_0000,  32'd4,         32'h0800_0000,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b0110, 32'hF0F0,       32'h0F0F,      32'hFFFF,       1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b0111, 32'hF0F0,       32'h0FF0,      32'h00F0,       1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 32'd1,          32'd2,         32'h0000_DEAD,  1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'b1000, 32'd9,          32'd9,         32'h0000_DEAD,  1'b0, 1'b1};

    // Reset state; readies stay low under reset even with a valid request.
    @(negedge clk);
    set_req(0, 1'b1, 4'b0000, 32'd1, 32'd1);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    check("rst_rsp_illegal", bus.rsp_illegal, 0);
    check("rst_req0_ready", bus.req0_ready, 0);

    // Contention after reset: req0 first, then req1.
    rst = 1'b0;
    set_req(0, 1'b1, 4'b1001, 32'd3, 32'd3);
    set_req(1, 1'b1, 4'b0100, 32'hF0, 32'h0F);
    #1;
    check("cont_req0_ready", bus.req0_ready, 1);
    check("cont_req1_ready", bus.req1_ready, 0);
    @(negedge clk);
    check("cont0_valid", bus.rsp_valid, 1);
    check("cont0_id", bus.rsp_id, 0);
    check("cont0_result", bus.rsp_result, 0);
    check("cont0_zero", bus.rsp_zero, 1);
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    #1;
    check("cont_req1_ready2", bus.req1_ready, 1);
    @(negedge clk);
    check("cont1_id", bus.rsp_id, 1);
    check("cont1_result", bus.rsp_result, 32'hFF);
    idle_inputs();
    @(negedge clk);
    check("drain_idle", bus.rsp_valid, 0);

    // Table of single-requester operations.
    for (int i = 0; i < 12; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].ctrl, vecs[i].a, vecs[i].b);
      set_req(!vecs[i].id, 1'b0, 4'h0, 32'd0, 32'd0);
      #1;
      check("vec_ready", vecs[i].id ? bus.req1_ready : bus.req0_ready, 1);
      check("vec_other_ready", vecs[i].id ? bus.req0_ready : bus.req1_ready, 0);
      @(negedge clk);
      check("vec_valid", bus.rsp_valid, 1);
      check("vec_id", bus.rsp_id, vecs[i].id);
      check("vec_result", bus.rsp_result, vecs[i].res);
      check("vec_zero", bus.rsp_zero, vecs[i].zero);
      check("vec_illegal", bus.rsp_illegal, vecs[i].ill);
    end
    idle_inputs();

    // Backpressure on an sra response, then drain and refill together.
    set_req(0, 1'b1, 4'b1101, 32'h8000_0000, 32'd4);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'b0000, 32'd1, 32'd1);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_result", bus.rsp_result, 32'hF800_0000);
      check("bp_id", bus.rsp_id, 0);
      check("bp_req0_ready", bus.req0_ready, 0);
      check("bp_req1_ready", bus.req1_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_refill_ready", bus.req1_ready, 1);
    @(negedge clk);
    check("bp_refill_id", bus.rsp_id, 1);
    check("bp_refill_result", bus.rsp_result, 32'd2);
    idle_inputs();

    // Reset while holding a response: rr must return to 0.
    set_req(0, 1'b1, 4'b0000, 32'd2, 32'd2);
    @(negedge clk);
    set_req(0, 1'b0, 4'h0, 32'd0, 32'd0);
    bus.rsp_ready = 1'b0;
    check("mid_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    set_req(0, 1'b1, 4'b0000, 32'd1, 32'd2);
    set_req(1, 1'b1, 4'b0000, 32'd4, 32'd4);
    #1;
    check("mid_rst_ready0", bus.req0_ready, 0);
    check("mid_rst_ready1", bus.req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", bus.rsp_valid, 0);
    #1;
    check("mid_after_ready0", bus.req0_ready, 1);
    check("mid_after_ready1", bus.req1_ready, 0);
    bus.rsp_ready = 1'b1;

    // Fairness: grants alternate while both requesters stay valid.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("fair_valid", bus.rsp_valid, 1);
      check("fair_id", bus.rsp_id, i % 2);
      check("fair_result", bus.rsp_result, (i % 2) ? 32'd8 : 32'd3);
    end

    // Randomized traffic against the transaction-level model.
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_held = 1'b0;
    m_id = 1'b0;
    m_rsp = '0;
    m_last = 1;
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; rv[n] = 1'b0; rc[n] = 4'h0; ra[n] = 32'd0; rb[n] = 32'd0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int  win;
      logic open;
      check("rnd_valid", bus.rsp_valid, m_held);
      if (m_held) begin
        check("rnd_id", bus.rsp_id, m_id);
        check("rnd_result", bus.rsp_result, m_rsp[31:0]);
        check("rnd_zero", bus.rsp_zero, m_rsp[32]);
        check("rnd_illegal", bus.rsp_illegal, m_rsp[33]);
      end
      for (int n = 0; n < 2; n++) begin
        if (pend[n]) begin
          if ($urandom_range(0, 9) == 0) rv[n] = 1'b0;
        end else begin
          rv[n] = ($urandom_range(0, 1) == 1);
          rc[n] = 4'($urandom_range(0, 15));
          ra[n] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
          rb[n] = ($urandom_range(0, 3) == 0) ? ra[n] : 32'($urandom_range(0, 40));
        end
        set_req(n, rv[n], rc[n], ra[n], rb[n]);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      open = !m_held || bus.rsp_ready;
      win = -1;
      if (open && (rv[0] || rv[1])) win = (rv[0] && rv[1]) ? 1 - m_last : (rv[1] ? 1 : 0);
      check("rnd_req0_ready", bus.req0_ready, win == 0);
      check("rnd_req1_ready", bus.req1_ready, win == 1);
      if (win >= 0) begin
        m_held = 1'b1;
        m_id = (win == 1);
        m_rsp = ref_alu(rc[win], ra[win], rb[win]);
        m_last = win;
        pend[win] = 1'b0;
        pend[1 - win] = rv[1 - win];
      end else begin
        if (m_held && bus.rsp_ready) m_held = 1'b0;
        pend[0] = rv[0];
        pend[1] = rv[1];
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 32 and the requester count fixed at 2.
REQ-002 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle.
REQ-006 req0_op1, req0_op2 / req1_op1, req1_op2  in  32  operands for requester n.
REQ-007 req0_ctrl / req1_ctrl  in  4  ALU control code for requester n.
REQ-008 rsp_valid  out  1  response held in output register.
REQ-009 rsp_ready  in  1  consumer takes the response this cycle.
REQ-010 rsp_id  out  1  index of the requester that owns the response.
REQ-011 rsp_result  out  32  registered ALU result.
REQ-012 rsp_zero  out  1  registered ALU Zero flag.
REQ-013 rsp_illegal  out  1  the captured ctrl was not a legal code.

Function
REQ-014 A single shared ALU instance SHALL compute for the granted requester only; operand/ctrl muxing SHALL be driven by the grant.
REQ-015 FSM states: IDLE (no response held), RESP (rsp_valid=1).
REQ-016 Accept window: open when state==IDLE, or when state==RESP and rsp_ready==1 (same-cycle drain and refill).
REQ-017 Grant: when exactly one req valid, grant it; when both valid, grant the requester indicated by the round-robin pointer rr.
REQ-018 reqN_ready SHALL be 1 only for the granted requester in an open accept window; it is combinational from the valids, rr, state and rsp_ready.
REQ-019 Transfer occurs when reqN_valid && reqN_ready; on transfer, the ALU output, Zero, the grant index and the illegal flag SHALL be registered; the next state is RESP. Latency: response valid 1 cycle after acceptance.
REQ-020 rr SHALL be set to the non-granted index after every transfer; it SHALL be unchanged when no transfer occurs.
REQ-021 RESP with rsp_ready==1 and no transfer -> IDLE; RESP with rsp_ready==0 -> stay RESP, all rsp_* outputs stable, both readies 0.
REQ-022 Legal ctrl codes: 0000 add, 1001 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and; any other code SHALL set rsp_illegal=1 and pass the ALU's 0x0000DEAD result through unchanged.
REQ-023 Throughput SHALL be one operation per cycle while rsp_ready is held at 1.
REQ-024 Requesters SHALL hold valid/operands until ready; a deasserted valid before acceptance SHALL be legal and cause no transfer.

Reset
REQ-025 rst=1 SHALL force state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0 and rr=0 on the next edge.
REQ-026 During rst=1, both readies SHALL be 0; a response held at reset assertion SHALL be discarded.

Structure
REQ-027 Package alu_pkg SHALL hold the 4-bit ctrl enum (the ten codes above), the arbiter state enum, and the constant ALU_ERR=32'h0000DEAD.
REQ-028 One sub-module SHALL be instantiated: the existing alu (ALUop1, ALUop2, ALUctrl, ALUout, Zero); the arbiter SHALL NOT reimplement ALU arithmetic.

Verification
REQ-029 Single request: req0 add 5+7, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-030 Contention after reset: both valid (req0 sub 3-3, req1 xor F0^0F) with rsp_ready=1 -> req0 granted first (rsp_result=0, rsp_zero=1), then req1 (rsp_result=0xFF, rsp_id=1).
REQ-031 Backpressure: rsp_ready=0 for 4 cycles holding an sra 0x80000000>>>4 response -> rsp_result=0xF8000000 stable, readies 0; rsp_ready=1 -> drain and accept the pending request in the same cycle.
REQ-032 Illegal op: req1 ctrl=1111 -> rsp_illegal=1, rsp_result=0x0000DEAD.
REQ-033 Reset mid-operation: rst pulsed while in RESP -> rsp_valid=0 next cycle, rr=0; subsequent contention grants req0 first.
REQ-034 Fairness: both valid continuously for 10 transfers -> grants strictly alternate 0,1,0,1...
